// File: rtl/calc_pkg.sv
// Shared types and opcode encoding for the button-driven calculator controller.
package calc_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StLatch = 2'd1,
      StExec  = 2'd2
   } state_e;

   // Opcodes named by the {l,c,r} button combination that selects them.
   localparam logic [3:0] OpSel0 = 4'b0010;  // add
   localparam logic [3:0] OpSel1 = 4'b0110;  // subtract
   localparam logic [3:0] OpSel2 = 4'b0000;  // and
   localparam logic [3:0] OpSel3 = 4'b0001;  // or
   localparam logic [3:0] OpSel4 = 4'b1101;
   localparam logic [3:0] OpSel5 = 4'b0111;
   localparam logic [3:0] OpSel6 = 4'b1001;
   localparam logic [3:0] OpSel7 = 4'b1010;

   localparam logic [3:0] OpReset = OpSel0;

   function automatic logic [3:0] encode_op(input logic l, input logic c, input logic r);
      logic [3:0] op;
      case ({l, c, r})
         3'b000:  op = OpSel0;
         3'b001:  op = OpSel1;
         3'b010:  op = OpSel2;
         3'b011:  op = OpSel3;
         3'b100:  op = OpSel4;
         3'b101:  op = OpSel5;
         3'b110:  op = OpSel6;
         default: op = OpSel7;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser chain plus stability counter for one raw push-button.
// level changes only after the synced input has disagreed with it for DEBOUNCE cycles.
module btn_debounce #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEBOUNCE    = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   prev_q;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (synced == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CntLast) begin
         level_d = synced;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
         cnt_q   <= cnt_d;
         level_q <= level_d;
         prev_q  <= level_q;
      end
   end

   assign level = level_q;
   assign rise  = level_q & ~prev_q;

endmodule

// File: rtl/calc_ctrl.sv
// Button-driven accumulator controller: debounces the board buttons, latches an opcode and
// operand, and runs one external-ALU operation per execute press.
module calc_ctrl #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEBOUNCE    = 4,
   parameter int unsigned COUNT_W     = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               btnl,
   input  logic               btnc,
   input  logic               btnr,
   input  logic               btnd,
   input  logic               btnu,
   input  logic [WIDTH-1:0]   sw,
   output logic [3:0]         alu_op,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   input  logic [WIDTH-1:0]   alu_result,
   input  logic               alu_zero,
   output logic [WIDTH-1:0]   accum,
   output logic               zero_flag,
   output logic               busy,
   output logic [COUNT_W-1:0] op_count
);

   import calc_pkg::*;

   // Button order within the vectors below: {u, d, l, c, r}.
   localparam int unsigned NumBtn = 5;

   logic [NumBtn-1:0] btn_raw;
   logic [NumBtn-1:0] btn_level;
   logic [NumBtn-1:0] btn_rise;

   assign btn_raw = {btnu, btnd, btnl, btnc, btnr};

   for (genvar i = 0; i < NumBtn; i++) begin : g_btn
      btn_debounce #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEBOUNCE    (DEBOUNCE)
      ) u_btn_debounce (
         .clk   (clk),
         .reset (reset),
         .raw   (btn_raw[i]),
         .level (btn_level[i]),
         .rise  (btn_rise[i])
      );
   end

   logic sel_l, sel_c, sel_r;
   logic exe_pulse, clr_pulse;
   logic unused_btn;

   assign sel_l     = btn_level[2];
   assign sel_c     = btn_level[1];
   assign sel_r     = btn_level[0];
   assign exe_pulse = btn_rise[3];
   assign clr_pulse = btn_rise[4];
   assign unused_btn = ^{btn_rise[2:0], btn_level[4:3]};

   state_e             state_q, state_d;
   logic [3:0]         op_q, op_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   accum_q, accum_d;
   logic               zero_q, zero_d;
   logic [COUNT_W-1:0] count_q, count_d;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      opb_d   = opb_q;
      accum_d = accum_q;
      zero_d  = zero_q;
      count_d = count_q;
      // Clear overrides everything, including an execute press or a pending EXEC write.
      if (clr_pulse) begin
         state_d = StIdle;
         accum_d = '0;
         zero_d  = 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               if (exe_pulse) begin
                  state_d = StLatch;
               end
            end
            StLatch: begin
               op_d    = encode_op(sel_l, sel_c, sel_r);
               opb_d   = sw;
               state_d = StExec;
            end
            StExec: begin
               accum_d = alu_result;
               zero_d  = alu_zero;
               count_d = count_q + COUNT_W'(1);
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         op_q    <= OpReset;
         opb_q   <= '0;
         accum_q <= '0;
         zero_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         opb_q   <= opb_d;
         accum_q <= accum_d;
         zero_q  <= zero_d;
         count_q <= count_d;
      end
   end

   assign alu_op    = op_q;
   assign alu_a     = accum_q;
   assign alu_b     = opb_q;
   assign accum     = accum_q;
   assign zero_flag = zero_q;
   assign busy      = (state_q != StIdle);
   assign op_count  = count_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl with a small behavioural ALU attached.
module tb_calc_ctrl;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned CW    = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             btnl, btnc, btnr, btnd, btnu;
   logic [WIDTH-1:0] sw;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] alu_a, alu_b, alu_result, accum;
   logic             alu_zero, zero_flag, busy;
   logic [CW-1:0]    op_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] alu_model(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      case (op)
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0000: return a & b;
         4'b0001: return a | b;
         default: return b;
      endcase
   endfunction

   assign alu_result = alu_model(alu_op, alu_a, alu_b);
   assign alu_zero   = (alu_result == '0);

   calc_ctrl #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (2),
      .DEBOUNCE    (4),
      .COUNT_W     (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btnl       (btnl),
      .btnc       (btnc),
      .btnr       (btnr),
      .btnd       (btnd),
      .btnu       (btnu),
      .sw         (sw),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .accum      (accum),
      .zero_flag  (zero_flag),
      .busy       (busy),
      .op_count   (op_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Hold btnd long enough to debounce high, then release it; counts busy cycles seen.
   task automatic press_d(output int busy_n);
      busy_n = 0;
      btnd = 1'b1;
      repeat (10) begin
         @(negedge clk);
         busy_n += int'(busy);
      end
      btnd = 1'b0;
      repeat (8) begin
         @(negedge clk);
         busy_n += int'(busy);
      end
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [3:0] op_tab [8];
   int         busy_n;
   int         exp_cnt;
   logic [WIDTH-1:0] exp_acc;

   initial begin
      op_tab = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1101, 4'b0111, 4'b1001, 4'b1010};
      reset = 1'b1;
      {btnl, btnc, btnr, btnd, btnu} = '0;
      sw = '0;
      settle(4);
      reset = 1'b0;
      settle(1);

      check("rst_accum", 32'(accum), 32'h0);
      check("rst_zero", 32'(zero_flag), 32'h0);
      check("rst_alu_op", 32'(alu_op), 32'h2);
      check("rst_alu_a", 32'(alu_a), 32'h0);
      check("rst_alu_b", 32'(alu_b), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_count", 32'(op_count), 32'h0);

      // Three-cycle glitch is one short of the debounce window.
      busy_n = 0;
      btnd = 1'b1;
      settle(3);
      btnd = 1'b0;
      repeat (12) begin
         @(negedge clk);
         busy_n += int'(busy);
      end
      check("glitch_busy", 32'(busy_n), 32'd0);
      check("glitch_accum", 32'(accum), 32'h0);

      sw = 16'h0005;
      press_d(busy_n);
      check("add_busy_cycles", 32'(busy_n), 32'd2);
      check("add_accum", 32'(accum), 32'h0005);
      check("add_alu_op", 32'(alu_op), 32'h2);
      check("add_count", 32'(op_count), 32'd1);
      check("add_zero", 32'(zero_flag), 32'h0);

      btnr = 1'b1;
      settle(8);
      press_d(busy_n);
      check("sub_alu_op", 32'(alu_op), 32'h6);
      check("sub_accum", 32'(accum), 32'h0000);
      check("sub_zero", 32'(zero_flag), 32'h1);
      check("sub_count", 32'(op_count), 32'd2);
      btnr = 1'b0;
      settle(8);

      sw = 16'h1234;
      press_d(busy_n);
      check("load_accum", 32'(accum), 32'h1234);
      check("load_count", 32'(op_count), 32'd3);

      // Clear and execute debounce in the same cycle: clear must win.
      busy_n = 0;
      btnd = 1'b1;
      btnu = 1'b1;
      repeat (10) begin
         @(negedge clk);
         busy_n += int'(busy);
      end
      btnd = 1'b0;
      btnu = 1'b0;
      settle(8);
      check("prio_busy", 32'(busy_n), 32'd0);
      check("prio_accum", 32'(accum), 32'h0);
      check("prio_zero", 32'(zero_flag), 32'h1);
      check("prio_count", 32'(op_count), 32'd3);

      // Clear arriving while EXEC is in progress cancels the write.
      sw = 16'h0007;
      btnd = 1'b1;
      settle(2);
      btnu = 1'b1;
      settle(6);
      check("cancel_in_exec", 32'(busy), 32'h1);
      settle(1);
      check("cancel_accum", 32'(accum), 32'h0);
      check("cancel_count", 32'(op_count), 32'd3);
      check("cancel_zero", 32'(zero_flag), 32'h1);
      check("cancel_busy", 32'(busy), 32'h0);
      check("cancel_keep_b", 32'(alu_b), 32'h0007);
      check("cancel_keep_op", 32'(alu_op), 32'h2);
      btnd = 1'b0;
      btnu = 1'b0;
      settle(10);

      exp_acc = '0;
      exp_cnt = 3;
      for (int i = 0; i < 8; i++) begin
         {btnl, btnc, btnr} = 3'(i);
         sw = 16'(16'h0101 * (i + 1));
         settle(8);
         press_d(busy_n);
         exp_acc = alu_model(op_tab[i], exp_acc, sw);
         exp_cnt = (exp_cnt + 1) % 4;
         check($sformatf("sweep%0d_op", i), 32'(alu_op), 32'(op_tab[i]));
         check($sformatf("sweep%0d_count", i), 32'(op_count), 32'(exp_cnt));
         check($sformatf("sweep%0d_accum", i), 32'(accum), 32'(exp_acc));
      end
      {btnl, btnc, btnr} = 3'b000;
      settle(8);

      // Reset during EXEC drops the pending write.
      sw = 16'h00ff;
      btnd = 1'b1;
      settle(8);
      check("rstmid_in_exec", 32'(busy), 32'h1);
      reset = 1'b1;
      btnd = 1'b0;
      settle(1);
      check("rstmid_accum", 32'(accum), 32'h0);
      check("rstmid_count", 32'(op_count), 32'd0);
      check("rstmid_zero", 32'(zero_flag), 32'h0);
      check("rstmid_busy", 32'(busy), 32'h0);
      check("rstmid_alu_op", 32'(alu_op), 32'h2);
      check("rstmid_alu_b", 32'(alu_b), 32'h0);
      reset = 1'b0;
      settle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
